perf_ovf_unit: RTL and testbench

// - Downstream consumer of the perf counter array; detects counter wrap-around and latches sticky overflow flags.
// - Raises a throttled, maskable overflow interrupt (irq_o) towards the CSR file / interrupt logic.
// - Sits between the perf counter block (perf_counter_o, its write strobe) and csr_regfile (CSR access, mip).

---
 rtl/perf_ovf_unit_pkg.sv | 24 ++
 rtl/perf_ovf_detect.sv | 39 +++
 rtl/perf_ovf_unit.sv | 143 ++++++++++++++
 tb/tb_perf_ovf_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_ovf_unit_pkg.sv
// Shared types and constants for the perf counter overflow unit.
// Holds counter geometry, CSR addresses and the irq FSM encoding.
package perf_ovf_unit_pkg;

  localparam int unsigned XLEN = 64;

  // Counter CSR window watched by the unit.
  localparam logic [11:0] CSR_ML1_ICACHE_MISS = 12'hB03;
  localparam logic [11:0] CSR_MIF_EMPTY       = 12'hB10;

  // Custom CSRs exposing the unit to software.
  localparam logic [11:0] CSR_OVF_STATUS = 12'h7C0;
  localparam logic [11:0] CSR_OVF_IRQ_EN = 12'h7C1;

  localparam int unsigned NrPerfCnt =
    int'(CSR_MIF_EMPTY - CSR_ML1_ICACHE_MISS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLDOFF
  } ovf_fsm_e;

endpackage

// File: rtl/perf_ovf_detect.sv
// Wrap detector for a single perf counter.
// Ports: clk_i/rst_i, msb_i (counter MSB), cnt_we_i/cnt_addr_i
// (software write), debug_mode_i, ovf_set_o (one-cycle set pulse).
module perf_ovf_detect
  import perf_ovf_unit_pkg::*;
#(
  parameter int unsigned Idx = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       msb_i,
  input  logic       cnt_we_i,
  input  logic [4:0] cnt_addr_i,
  input  logic       debug_mode_i,
  output logic       ovf_set_o
);

  logic prev_msb_q;
  logic wr_mask_q;
  logic hit;

  assign hit = cnt_we_i && (cnt_addr_i == 5'(Idx));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_msb_q <= 1'b0;
      wr_mask_q  <= 1'b0;
    end else begin
      prev_msb_q <= msb_i;
      // The counter takes the written value one cycle
      // after the strobe, so the mask is delayed to match.
      wr_mask_q  <= hit;
    end
  end

  assign ovf_set_o = prev_msb_q & ~msb_i
                   & ~wr_mask_q & ~debug_mode_i;

endmodule

// File: rtl/perf_ovf_unit.sv
// Perf counter overflow unit: sticky wrap flags plus a
// throttled, maskable level interrupt towards the CSR file.
// Ports: clk_i, rst_i (async, active-high), debug_mode_i,
// perf_counter_i (NrCnt*XLEN), cnt_we_i, cnt_addr_i,
// csr_sel_i (0 status / 1 irq enable), csr_we_i,
// csr_wdata_i, csr_rdata_o, ovf_status_o, irq_o.
module perf_ovf_unit
  import perf_ovf_unit_pkg::*;
#(
  parameter int unsigned NrCnt      = NrPerfCnt,
  parameter int unsigned HoldoffCyc = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  debug_mode_i,
  input  logic [NrCnt*XLEN-1:0] perf_counter_i,
  input  logic                  cnt_we_i,
  input  logic [4:0]            cnt_addr_i,
  input  logic                  csr_sel_i,
  input  logic                  csr_we_i,
  input  logic [NrCnt-1:0]      csr_wdata_i,
  output logic [NrCnt-1:0]      csr_rdata_o,
  output logic [NrCnt-1:0]      ovf_status_o,
  output logic                  irq_o
);

  localparam int unsigned HoldW =
    (HoldoffCyc > 0) ? $clog2(HoldoffCyc + 1) : 1;

  logic [NrCnt-1:0] ovf_set;
  logic [NrCnt-1:0] status_q, status_d;
  logic [NrCnt-1:0] irq_en_q;
  logic             pend;

  ovf_fsm_e   state_q, state_d;
  logic       irq_q, irq_d;
  logic [HoldW-1:0] hcnt_q, hcnt_d;

  // Only the MSBs feed the detectors.
  logic unused_cnt;
  assign unused_cnt = ^perf_counter_i;

  for (genvar i = 0; i < NrCnt; i++) begin : g_det
    perf_ovf_detect #(
      .Idx(i)
    ) u_det (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .msb_i       (perf_counter_i[i*XLEN+XLEN-1]),
      .cnt_we_i    (cnt_we_i),
      .cnt_addr_i  (cnt_addr_i),
      .debug_mode_i(debug_mode_i),
      .ovf_set_o   (ovf_set[i])
    );
  end

  // Write-1-to-clear; a fresh wrap beats a same-cycle clear.
  always_comb begin
    status_d = status_q;
    if (csr_we_i && !csr_sel_i) begin
      status_d = status_q & ~csr_wdata_i;
    end
    status_d = status_d | ovf_set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q <= '0;
      irq_en_q <= '0;
    end else begin
      status_q <= status_d;
      if (csr_we_i && csr_sel_i) begin
        irq_en_q <= csr_wdata_i;
      end
    end
  end

  assign pend = |(status_q & irq_en_q);

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (pend) begin
          state_d = ASSERT;
          irq_d   = 1'b1;
        end
      end
      ASSERT: begin
        irq_d = 1'b1;
        if (!pend) begin
          irq_d = 1'b0;
          if (HoldoffCyc == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLDOFF;
            hcnt_d  = HoldW'(HoldoffCyc - 1);
          end
        end
      end
      HOLDOFF: begin
        irq_d = 1'b0;
        if (hcnt_q == '0) begin
          // Expiry with work already pending goes straight
          // back up, so the low gap is exactly HoldoffCyc.
          if (pend) begin
            state_d = ASSERT;
            irq_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hcnt_d = hcnt_q - HoldW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign irq_o        = irq_q;
  assign ovf_status_o = status_q;
  assign csr_rdata_o  = csr_sel_i ? irq_en_q : status_q;

endmodule

// File: tb/tb_perf_ovf_unit.sv
// Self-checking bench for perf_ovf_unit: directed scenarios
// followed by random traffic against a behavioural model.
module tb_perf_ovf_unit;

  localparam int NR   = 14;
  localparam int HOLD = 16;

  logic              clk;
  logic              rst_i;
  logic              debug_mode;
  logic [NR*64-1:0]  perf_counter;
  logic              cnt_we;
  logic [4:0]        cnt_addr;
  logic              csr_sel;
  logic              csr_we;
  logic [NR-1:0]     csr_wdata;
  logic [NR-1:0]     csr_rdata;
  logic [NR-1:0]     ovf_status;
  logic              irq;

  logic [63:0] cnt [NR];

  // Model state
  logic [NR-1:0] m_status;
  logic [NR-1:0] m_en;
  logic          m_irq;
  int            m_fall;
  int            ecount;
  logic [63:0]   m_prev_cnt [NR];
  logic [NR-1:0] m_wr_prev;

  int n_chk;
  int n_fail;
  int low;

  perf_ovf_unit #(
    .NrCnt     (NR),
    .HoldoffCyc(HOLD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .debug_mode_i  (debug_mode),
    .perf_counter_i(perf_counter),
    .cnt_we_i      (cnt_we),
    .cnt_addr_i    (cnt_addr),
    .csr_sel_i     (csr_sel),
    .csr_we_i      (csr_we),
    .csr_wdata_i   (csr_wdata),
    .csr_rdata_o   (csr_rdata),
    .ovf_status_o  (ovf_status),
    .irq_o         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    perf_counter = '0;
    for (int i = 0; i < NR; i++) begin
      perf_counter[i*64 +: 64] = cnt[i];
    end
  end

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_status"}, 64'(ovf_status), 64'(m_status));
    chk({tag, "_irq"}, 64'(irq), 64'(m_irq));
    chk({tag, "_rdata"}, 64'(csr_rdata),
        csr_sel ? 64'(m_en) : 64'(m_status));
  endtask

  task automatic model_reset();
    m_status  = '0;
    m_en      = '0;
    m_irq     = 1'b0;
    m_fall    = -1000;
    m_wr_prev = '0;
    for (int i = 0; i < NR; i++) m_prev_cnt[i] = '0;
  endtask

  // Advance one clock: predict from pre-edge inputs, then
  // compare shortly after the edge.
  task automatic tick(string tag = "cyc");
    logic [NR-1:0] wrap;
    logic [NR-1:0] st_n;
    logic          pend;
    pend = |(m_status & m_en);
    for (int i = 0; i < NR; i++) begin
      wrap[i] = m_prev_cnt[i][63] && !cnt[i][63]
             && !m_wr_prev[i] && !debug_mode;
    end
    st_n = m_status;
    if (csr_we && !csr_sel) st_n = st_n & ~csr_wdata;
    st_n = st_n | wrap;
    ecount++;
    // irq follows pend, but may only rise HOLD edges
    // after its last fall.
    if (m_irq) begin
      if (!pend) begin
        m_irq  = 1'b0;
        m_fall = ecount;
      end
    end else if (pend && (ecount - m_fall >= HOLD)) begin
      m_irq = 1'b1;
    end
    if (csr_we && csr_sel) m_en = csr_wdata;
    m_status = st_n;
    for (int i = 0; i < NR; i++) begin
      m_prev_cnt[i] = cnt[i];
      m_wr_prev[i]  = cnt_we && (int'(cnt_addr) == i);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_rst();
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("rst_status", 64'(ovf_status), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    #2;
    rst_i = 1'b0;
  endtask

  task automatic csr_wr(logic sel, logic [NR-1:0] d);
    csr_we    = 1'b1;
    csr_sel   = sel;
    csr_wdata = d;
    tick("csr");
    csr_we    = 1'b0;
    csr_wdata = '0;
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    ecount     = 0;
    rst_i      = 1'b1;
    debug_mode = 1'b0;
    cnt_we     = 1'b0;
    cnt_addr   = '0;
    csr_sel    = 1'b0;
    csr_we     = 1'b0;
    csr_wdata  = '0;
    for (int i = 0; i < NR; i++) cnt[i] = '0;
    model_reset();
    #2;
    pulse_rst();
    tick("idle");

    // A: counter 3 wraps with EN[3] set
    csr_wr(1'b1, 14'h0008);
    cnt[3] = '1;
    tick("a_pre");
    cnt[3] = '0;
    tick("a_wrap");
    chk("a_status3", 64'(ovf_status), 64'h8);
    chk("a_irq_lat0", 64'(irq), 64'd0);
    tick("a_irq");
    chk("a_irq_lat1", 64'(irq), 64'd1);

    // Holdoff: clear while asserted, rewrap two cycles on
    csr_wr(1'b0, 14'h0008);
    cnt[3] = '1;
    tick("h_fall");
    chk("h_irq_fell", 64'(irq), 64'd0);
    cnt[3] = '0;
    low = 0;
    for (int k = 0; k < 40 && irq === 1'b0; k++) begin
      low++;
      tick("h_wait");
    end
    chk("holdoff_len", 64'(low), 64'd16);
    chk("holdoff_irq", 64'(irq), 64'd1);

    csr_wr(1'b1, 14'h0000);
    csr_wr(1'b0, 14'h3FFF);
    repeat (3) tick("cleanup");

    // B: software write clears MSB -> no flag
    csr_wr(1'b1, 14'h0020);
    cnt[5] = 64'h8000_0000_0000_0000;
    tick("b_pre");
    tick("b_pre");
    cnt_we   = 1'b1;
    cnt_addr = 5'd5;
    tick("b_we");
    cnt_we = 1'b0;
    cnt[5] = '0;
    tick("b_val");
    chk("b_status5", 64'(ovf_status[5]), 64'd0);
    tick("b_after");
    chk("b_irq", 64'(irq), 64'd0);
    csr_wr(1'b1, 14'h0000);

    // C: set beats same-cycle W1C
    cnt[2] = '1;
    tick("c_pre");
    cnt[2] = '0;
    tick("c_wrap1");
    chk("c_first", 64'(ovf_status), 64'h4);
    cnt[2] = '1;
    tick("c_pre2");
    cnt[2]    = '0;
    csr_we    = 1'b1;
    csr_sel   = 1'b0;
    csr_wdata = 14'h0004;
    tick("c_race");
    csr_we = 1'b0;
    chk("c_set_wins", 64'(ovf_status), 64'h4);
    csr_wr(1'b0, 14'h0004);
    chk("c_cleared", 64'(ovf_status), 64'h0);

    repeat (20) tick("gap");

    // D: two wraps with enables off, then enable bit 0
    cnt[0]  = '1;
    cnt[13] = '1;
    tick("d_pre");
    cnt[0]  = '0;
    cnt[13] = '0;
    tick("d_wrap");
    chk("d_status", 64'(ovf_status), 64'h2001);
    chk("d_irq_off", 64'(irq), 64'd0);
    csr_wr(1'b1, 14'h0001);
    chk("d_irq_en1", 64'(irq), 64'd0);
    tick("d_en2");
    chk("d_irq_en2", 64'(irq), 64'd1);

    // E: debug suppresses detection; reset kills irq
    debug_mode = 1'b1;
    cnt[7] = '1;
    tick("e_pre");
    cnt[7] = '0;
    tick("e_wrap");
    debug_mode = 1'b0;
    tick("e_post");
    chk("e_dbg_status", 64'(ovf_status), 64'h2001);
    chk("e_irq_still", 64'(irq), 64'd1);
    pulse_rst();
    chk("e_rdata", 64'(csr_rdata), 64'd0);
    tick("e_after_rst");
    chk("e_no_irq", 64'(irq), 64'd0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (cnt[i] == '1) begin
          if ($urandom_range(0, 1) == 0) cnt[i] = '0;
        end else if ($urandom_range(0, 7) == 0) begin
          cnt[i] = '1;
        end else if ($urandom_range(0, 15) == 0) begin
          cnt[i] = {$urandom, $urandom};
        end
      end
      cnt_we     = ($urandom_range(0, 3) == 0);
      cnt_addr   = 5'($urandom_range(0, 17));
      csr_we     = ($urandom_range(0, 5) == 0);
      csr_sel    = 1'($urandom_range(0, 1));
      csr_wdata  = 14'($urandom);
      debug_mode = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) pulse_rst();
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
